// File: rtl/dcache_controller_if.sv
// Bundle of CPU, tag/data SRAM and data-memory signals around the L1 data-cache controller.
// The controller takes the slave view; the CPU/SRAM/memory environment takes the master view.
interface dcache_controller_if #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 23
);
  logic                 cpu_req;
  logic                 cpu_write;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [31:0]          cpu_rdata;
  logic                 cpu_stall;

  logic                 sram_enable;
  logic                 sram_write;
  logic [IDX_W-1:0]     sram_addr;
  logic [TAG_W+1:0]     sram_wtag;
  logic [255:0]         sram_wdata;
  logic [TAG_W+1:0]     sram_rtag;
  logic [255:0]         sram_rdata;
  logic                 sram_hit;

  logic                 mem_enable;
  logic                 mem_write;
  logic [31:0]          mem_addr;
  logic [255:0]         mem_wdata;
  logic [255:0]         mem_rdata;
  logic                 mem_ack;

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata,
    input  sram_rtag, sram_rdata, sram_hit,
    input  mem_rdata, mem_ack,
    output cpu_rdata, cpu_stall,
    output sram_enable, sram_write, sram_addr, sram_wtag, sram_wdata,
    output mem_enable, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata,
    output sram_rtag, sram_rdata, sram_hit,
    output mem_rdata, mem_ack,
    input  cpu_rdata, cpu_stall,
    input  sram_enable, sram_write, sram_addr, sram_wtag, sram_wdata,
    input  mem_enable, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_controller.sv
// Write-back, write-allocate L1 data-cache controller: hit/miss detection, store merge,
// dirty-victim writeback and line refill against a pulse-request/pulse-ack data memory.
//
// state  | meaning
// IDLE   | lookup; hits complete here, a miss moves on
// MISS   | victim visible on the SRAM port; issue writeback or refill request
// WBACK  | waiting for the writeback ack, then issue the refill request
// REFILL | waiting for the refill ack; write the (merged) line into the SRAM
// FILLED | let the SRAM lookup see the new line before returning to IDLE
module dcache_controller #(
  parameter int IDX_W = 4,
  parameter int OFS_W = 5,
  parameter int TAG_W = 23
) (
  input  logic clk_i,
  input  logic rst_i,
  dcache_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MISS   = 3'd1,
    WBACK  = 3'd2,
    REFILL = 3'd3,
    FILLED = 3'd4
  } state_t;

  state_t state;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word_sel;
  logic             victim_dirty;
  logic             unused_addr_bits;

  function automatic logic [255:0] merge_word(input logic [255:0] line,
                                              input logic [2:0]   sel,
                                              input logic [31:0]  word);
    logic [255:0] merged;
    merged = line;
    merged[{sel, 5'b0} +: 32] = word;
    return merged;
  endfunction

  assign idx              = bus.cpu_addr[OFS_W +: IDX_W];
  assign tag              = bus.cpu_addr[31 -: TAG_W];
  assign word_sel         = bus.cpu_addr[4:2];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];
  assign victim_dirty     = bus.sram_rtag[TAG_W+1] & bus.sram_rtag[TAG_W];

  assign bus.sram_addr   = idx;
  assign bus.sram_enable = bus.cpu_req | (state != IDLE);
  assign bus.cpu_stall   = bus.cpu_req & (~bus.sram_hit | (state != IDLE));
  assign bus.cpu_rdata   = bus.sram_rdata[{word_sel, 5'b0} +: 32];

  // Store hits write in the lookup cycle; refills write in the ack cycle, so a store miss
  // lands in the SRAM already merged and dirty.
  always_comb begin
    bus.sram_write = 1'b0;
    bus.sram_wtag  = '0;
    bus.sram_wdata = '0;
    if (state == IDLE && bus.cpu_req && bus.sram_hit && bus.cpu_write) begin
      bus.sram_write = 1'b1;
      bus.sram_wtag  = {1'b1, 1'b1, tag};
      bus.sram_wdata = merge_word(bus.sram_rdata, word_sel, bus.cpu_wdata);
    end else if (state == REFILL && bus.mem_ack) begin
      bus.sram_write = 1'b1;
      bus.sram_wtag  = {1'b1, bus.cpu_write, tag};
      bus.sram_wdata = bus.cpu_write ? merge_word(bus.mem_rdata, word_sel, bus.cpu_wdata)
                                     : bus.mem_rdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      bus.mem_enable <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.mem_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req && !bus.sram_hit) state <= MISS;
        end
        MISS: begin
          bus.mem_enable <= 1'b1;
          if (victim_dirty) begin
            bus.mem_write <= 1'b1;
            bus.mem_addr  <= {bus.sram_rtag[TAG_W-1:0], idx, {OFS_W{1'b0}}};
            bus.mem_wdata <= bus.sram_rdata;
            state         <= WBACK;
          end else begin
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= {bus.cpu_addr[31:OFS_W], {OFS_W{1'b0}}};
            state         <= REFILL;
          end
        end
        WBACK: begin
          if (bus.mem_ack) begin
            bus.mem_enable <= 1'b1;
            bus.mem_write  <= 1'b0;
            bus.mem_addr   <= {bus.cpu_addr[31:OFS_W], {OFS_W{1'b0}}};
            state          <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_ack) state <= FILLED;
        end
        FILLED: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: 2-way LRU tag/data SRAM model plus a fixed-latency
// data memory that answers each request pulse with an ack pulse ACK_DLY cycles later.
module tb_dcache_controller;

  localparam int ACK_DLY      = 10;
  // lookup + MISS + request..ack window (ACK_DLY+1 cycles) + FILLED
  localparam int CLEAN_STALLS = ACK_DLY + 4;
  localparam int DIRTY_STALLS = 2 * (ACK_DLY + 1) + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_controller_if bus ();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] line_for(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = (a >> 5) * 32'h100 + k;
    return l;
  endfunction

  // 2-way SRAM model: lookup returns the hit way, else the LRU victim
  logic [24:0]  tag_mem  [2][16];
  logic [255:0] data_mem [2][16];
  logic         lru      [16];
  logic         h0, h1, way;
  logic [3:0]   set;
  logic [22:0]  ctag;
  logic [24:0]  wq_tag  [$];
  logic [255:0] wq_data [$];

  always_comb begin
    set            = bus.sram_addr;
    ctag           = bus.cpu_addr[31:9];
    h0             = tag_mem[0][set][24] && (tag_mem[0][set][22:0] == ctag);
    h1             = tag_mem[1][set][24] && (tag_mem[1][set][22:0] == ctag);
    way            = h0 ? 1'b0 : (h1 ? 1'b1 : lru[set]);
    bus.sram_hit   = h0 | h1;
    bus.sram_rtag  = tag_mem[way][set];
    bus.sram_rdata = data_mem[way][set];
  end

  initial begin
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 16; s++) begin
        tag_mem[w][s]  <= '0;
        data_mem[w][s] <= '0;
      end
    for (int s = 0; s < 16; s++) lru[s] <= 1'b0;
    forever begin
      @(posedge clk);
      if (bus.sram_enable && bus.sram_write) begin
        tag_mem[way][set]  <= bus.sram_wtag;
        data_mem[way][set] <= bus.sram_wdata;
        wq_tag.push_back(bus.sram_wtag);
        wq_data.push_back(bus.sram_wdata);
      end
      if (bus.cpu_req && !bus.cpu_stall && bus.sram_hit) lru[set] <= ~way;
    end
  end

  // Data memory: logs every request pulse, acks ACK_DLY cycles after it
  logic [31:0]  pq_addr [$];
  logic         pq_wr   [$];
  logic [255:0] pq_data [$];
  int           ack_cd;
  int           back2back;
  int           acks_seen;
  int           wr_at_ack;
  logic         prev_en;
  logic [31:0]  cur_addr;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    ack_cd        = -1;
    back2back     = 0;
    acks_seen     = 0;
    wr_at_ack     = 0;
    prev_en       = 1'b0;
    cur_addr      = '0;
    forever begin
      @(negedge clk);
      if (ack_cd == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = line_for(cur_addr);
        wr_at_ack     = wq_tag.size();
        acks_seen++;
        ack_cd        = -1;
      end else begin
        bus.mem_ack = 1'b0;
        if (ack_cd > 0) ack_cd--;
      end
      if (bus.mem_enable) begin
        if (prev_en) back2back++;
        pq_addr.push_back(bus.mem_addr);
        pq_wr.push_back(bus.mem_write);
        pq_data.push_back(bus.mem_wdata);
        cur_addr = bus.mem_addr;
        ack_cd   = ACK_DLY - 1;
      end
      prev_en = bus.mem_enable;
    end
  end

  // Called 1 time unit after a rising edge; returns the same offset.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output int stalls, output logic [31:0] rd);
    stalls        = 0;
    bus.cpu_req   = 1'b1;
    bus.cpu_write = wr;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    #1;
    while (bus.cpu_stall && stalls < 200) begin
      @(posedge clk);
      #2;
      stalls++;
    end
    if (stalls >= 200) check("access_timeout", bus.cpu_stall, 1'b0);
    rd = bus.cpu_rdata;
    @(posedge clk);
    #1;
    bus.cpu_req   = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           st;
    logic [31:0]  rd;
    int           n0, w0, a0;
    logic [255:0] exp_line;

    bus.cpu_req   = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_enable", bus.mem_enable, 1'b0);
    check("rst_mem_write", bus.mem_write, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 256'h0);
    check("rst_sram_enable", bus.sram_enable, 1'b0);
    check("rst_cpu_stall", bus.cpu_stall, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1 cold read miss
    n0 = pq_addr.size();
    access(1'b0, 32'h20, 32'h0, st, rd);
    check("t1_stalls", st, CLEAN_STALLS);
    check("t1_data", rd, 32'h100);
    check("t1_pulses", pq_addr.size() - n0, 1);
    check("t1_addr", pq_addr[n0], 32'h20);
    check("t1_rw", pq_wr[n0], 1'b0);
    check("t1_tag", wq_tag[$], {2'b10, 23'd0});

    // T2 read hit
    n0 = pq_addr.size();
    access(1'b0, 32'h24, 32'h0, st, rd);
    check("t2_stalls", st, 0);
    check("t2_data", rd, 32'h101);
    check("t2_pulses", pq_addr.size() - n0, 0);

    // T3 store hit
    w0 = wq_tag.size();
    exp_line = line_for(32'h20);
    exp_line[64 +: 32] = 32'hDEADBEEF;
    access(1'b1, 32'h28, 32'hDEADBEEF, st, rd);
    check("t3_stalls", st, 0);
    check("t3_writes", wq_tag.size() - w0, 1);
    check("t3_tag", wq_tag[w0], {2'b11, 23'd0});
    check("t3_line", wq_data[w0], exp_line);
    access(1'b0, 32'h28, 32'h0, st, rd);
    check("t3_readback", rd, 32'hDEADBEEF);

    // T4 dirty victim eviction in set 1
    access(1'b0, 32'h220, 32'h0, st, rd);
    check("t4_fill_stalls", st, CLEAN_STALLS);
    check("t4_fill_data", rd, 32'h1100);
    access(1'b1, 32'h20, 32'hCAFEF00D, st, rd);
    access(1'b0, 32'h220, 32'h0, st, rd);
    check("t4_touch_stalls", st, 0);
    exp_line[31:0] = 32'hCAFEF00D;
    n0 = pq_addr.size();
    w0 = wq_tag.size();
    access(1'b0, 32'h420, 32'h0, st, rd);
    check("t4_stalls", st, DIRTY_STALLS);
    check("t4_pulses", pq_addr.size() - n0, 2);
    check("t4_wb_rw", pq_wr[n0], 1'b1);
    check("t4_wb_addr", pq_addr[n0], 32'h20);
    check("t4_wb_line", pq_data[n0], exp_line);
    check("t4_rd_rw", pq_wr[n0+1], 1'b0);
    check("t4_rd_addr", pq_addr[n0+1], 32'h420);
    check("t4_no_early_write", wr_at_ack, w0);
    check("t4_data", rd, 32'h2100);
    check("t4_fill_tag", wq_tag[w0], {2'b10, 23'd2});

    // T5 store miss into empty set 2
    w0 = wq_tag.size();
    exp_line = line_for(32'h640);
    exp_line[31:0] = 32'h12345678;
    access(1'b1, 32'h640, 32'h12345678, st, rd);
    check("t5_stalls", st, CLEAN_STALLS);
    check("t5_tag", wq_tag[w0], {2'b11, 23'd3});
    check("t5_line", wq_data[w0], exp_line);
    access(1'b0, 32'h640, 32'h0, st, rd);
    check("t5_readback", rd, 32'h12345678);

    // T6 reset during writeback, stale ack afterwards
    access(1'b1, 32'h60, 32'hA5A5A5A5, st, rd);
    access(1'b0, 32'h260, 32'h0, st, rd);
    n0 = pq_addr.size();
    w0 = wq_tag.size();
    bus.cpu_req   = 1'b1;
    bus.cpu_write = 1'b0;
    bus.cpu_addr  = 32'h460;
    for (int i = 0; i < 20 && pq_addr.size() == n0; i++) begin
      @(posedge clk);
      #1;
    end
    check("t6_wb_pulse", pq_addr.size() - n0, 1);
    check("t6_wb_rw", pq_wr[n0], 1'b1);
    @(posedge clk);
    #1;
    a0 = acks_seen;
    rst         = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    check("t6_rst_mem_enable", bus.mem_enable, 1'b0);
    check("t6_rst_mem_addr", bus.mem_addr, 32'h0);
    check("t6_rst_idle", bus.sram_enable, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (ACK_DLY + 5) @(posedge clk);
    #1;
    check("t6_stale_ack_seen", acks_seen - a0, 1);
    check("t6_no_sram_write", wq_tag.size() - w0, 0);
    check("t6_no_new_pulse", pq_addr.size() - n0, 1);
    check("t6_idle", bus.sram_enable, 1'b0);
    access(1'b0, 32'h60, 32'h0, st, rd);
    check("t6_after_stalls", st, 0);
    check("t6_after_data", rd, 32'hA5A5A5A5);

    check("no_back_to_back_enable", back2back, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
